// File: rtl/ped_walk_ctrl.sv
// Pedestrian WALK / flashing / steady DONT_WALK heads for two crossings, driven by the six-phase light bus.
// Lamps are registered one cycle behind crossing state; illegal light patterns latch a sticky fault forcing DONT_WALK.

module ped_walk_xing #(
  parameter int unsigned     CW         = 25,
  parameter logic [CW-1:0]   WALK_CYC   = CW'(20000000),
  parameter logic [CW-1:0]   FLASH_HALF = CW'(5000000),
  parameter logic [5:0]      GREEN      = 6'b100001
) (
  input  logic       clk_i,
  input  logic       clr_n_i,
  input  logic [5:0] lights_i,
  input  logic [5:0] prev_i,
  input  logic       btn_i,
  input  logic       illegal_i,
  input  logic       fault_i,
  output logic       walk_o,
  output logic       dw_o,
  output logic       req_o
);

  typedef enum logic [1:0] {ST_DW, ST_WALK, ST_FLASH} state_e;

  state_e        state_q;
  logic [CW-1:0] cnt_q;
  logic          tog_q;
  logic          req_q;
  logic          walk_q;
  logic          dw_q;

  logic          on_green;
  logic          phase_start;
  logic          grant;
  logic          req_d;

  always_comb begin
    on_green    = (lights_i == GREEN);
    phase_start = on_green && (prev_i != GREEN);
    grant       = (state_q == ST_DW) && phase_start && !fault_i && (req_q || btn_i);
    // A press on the granting edge is absorbed by the phase it starts.
    req_d       = grant ? 1'b0 : (req_q || btn_i);
  end

  always_ff @(posedge clk_i or negedge clr_n_i) begin
    if (!clr_n_i) begin
      state_q <= ST_DW;
      cnt_q   <= '0;
      tog_q   <= 1'b1;
      req_q   <= 1'b0;
      walk_q  <= 1'b0;
      dw_q    <= 1'b1;
    end else begin
      req_q  <= req_d;
      walk_q <= (state_q == ST_WALK);
      dw_q   <= (state_q == ST_DW) || ((state_q == ST_FLASH) && tog_q);
      if (illegal_i) begin
        state_q <= ST_DW;
        cnt_q   <= '0;
        tog_q   <= 1'b1;
      end else begin
        case (state_q)
          ST_DW: begin
            cnt_q <= '0;
            tog_q <= 1'b1;
            if (grant) state_q <= ST_WALK;
          end
          ST_WALK: begin
            if (!on_green) begin
              state_q <= ST_DW;
              cnt_q   <= '0;
            end else if (cnt_q == WALK_CYC - CW'(1)) begin
              state_q <= ST_FLASH;
              cnt_q   <= '0;
              tog_q   <= 1'b1;
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
          end
          ST_FLASH: begin
            if (!on_green) begin
              state_q <= ST_DW;
              cnt_q   <= '0;
              tog_q   <= 1'b1;
            end else if (cnt_q == FLASH_HALF - CW'(1)) begin
              cnt_q <= '0;
              tog_q <= ~tog_q;
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
          end
          default: begin
            state_q <= ST_DW;
            cnt_q   <= '0;
            tog_q   <= 1'b1;
          end
        endcase
      end
    end
  end

  assign walk_o = walk_q;
  assign dw_o   = dw_q;
  assign req_o  = req_q;

endmodule

module ped_walk_ctrl #(
  parameter int unsigned   CW         = 25,
  parameter logic [CW-1:0] WALK_CYC   = CW'(20000000),
  parameter logic [CW-1:0] FLASH_HALF = CW'(5000000)
) (
  input  logic       clk,
  input  logic       clr_n,
  input  logic [5:0] lights,
  input  logic       btn_a,
  input  logic       btn_b,
  output logic       walk_a,
  output logic       dw_a,
  output logic       walk_b,
  output logic       dw_b,
  output logic       req_a,
  output logic       req_b,
  output logic       fault
);

  logic [5:0] prev_q;
  logic       fault_q;
  logic       illegal;

  always_comb begin
    case (lights)
      6'b100001, 6'b100010, 6'b100100, 6'b001100, 6'b010100: illegal = 1'b0;
      default:                                               illegal = 1'b1;
    endcase
  end

  // prev_q resets to all-red so a green present right after reset still counts as a phase start.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      prev_q  <= 6'b100100;
      fault_q <= 1'b0;
    end else begin
      prev_q  <= lights;
      fault_q <= fault_q || illegal;
    end
  end

  // Crossing A walks across road A while road B has green, and vice versa.
  ped_walk_xing #(
    .CW(CW), .WALK_CYC(WALK_CYC), .FLASH_HALF(FLASH_HALF), .GREEN(6'b100001)
  ) u_xing_a (
    .clk_i     (clk),
    .clr_n_i   (clr_n),
    .lights_i  (lights),
    .prev_i    (prev_q),
    .btn_i     (btn_a),
    .illegal_i (illegal),
    .fault_i   (fault_q),
    .walk_o    (walk_a),
    .dw_o      (dw_a),
    .req_o     (req_a)
  );

  ped_walk_xing #(
    .CW(CW), .WALK_CYC(WALK_CYC), .FLASH_HALF(FLASH_HALF), .GREEN(6'b001100)
  ) u_xing_b (
    .clk_i     (clk),
    .clr_n_i   (clr_n),
    .lights_i  (lights),
    .prev_i    (prev_q),
    .btn_i     (btn_b),
    .illegal_i (illegal),
    .fault_i   (fault_q),
    .walk_o    (walk_b),
    .dw_o      (dw_b),
    .req_o     (req_b)
  );

  assign fault = fault_q;

endmodule

// File: tb/tb_ped_walk_ctrl.sv
// Bench for ped_walk_ctrl: elapsed-time model checked every cycle plus directed literal checkpoints.
module tb_ped_walk_ctrl;

  localparam int W = 8;
  localparam int H = 2;
  localparam logic [5:0] GA = 6'b100001;
  localparam logic [5:0] GB = 6'b001100;

  logic       clk = 1'b0;
  logic       clr_n = 1'b1;
  logic [5:0] lights = 6'b100100;
  logic       btn_a = 1'b0;
  logic       btn_b = 1'b0;
  logic       walk_a, dw_a, walk_b, dw_b, req_a, req_b, fault;

  int n_chk = 0;
  int n_fail = 0;
  int cnt_wa = 0;
  int cnt_wb = 0;
  bit chk_en = 1'b0;

  ped_walk_ctrl #(.CW(25), .WALK_CYC(25'd8), .FLASH_HALF(25'd2)) dut (
    .clk(clk), .clr_n(clr_n), .lights(lights), .btn_a(btn_a), .btn_b(btn_b),
    .walk_a(walk_a), .dw_a(dw_a), .walk_b(walk_b), .dw_b(dw_b),
    .req_a(req_a), .req_b(req_b), .fault(fault)
  );

  always #5 clk = ~clk;

  // Model: a crossing is either idle or active with an elapsed edge count since its grant.
  logic [5:0] m_prev;
  bit         m_fault;
  bit         m_act[2];
  int         m_el[2];
  bit         m_req[2];
  bit         m_walk[2];
  bit         m_dw[2];

  function automatic bit legal(input logic [5:0] l);
    return (l == 6'b100001) || (l == 6'b100010) || (l == 6'b100100) ||
           (l == 6'b001100) || (l == 6'b010100);
  endfunction

  function automatic logic [5:0] green(input int x);
    return (x == 0) ? GA : GB;
  endfunction

  always @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      m_prev  <= 6'b100100;
      m_fault <= 1'b0;
      for (int x = 0; x < 2; x++) begin
        m_act[x]  <= 1'b0;
        m_el[x]   <= 0;
        m_req[x]  <= 1'b0;
        m_walk[x] <= 1'b0;
        m_dw[x]   <= 1'b1;
      end
    end else begin
      m_prev <= lights;
      if (!legal(lights)) m_fault <= 1'b1;
      for (int x = 0; x < 2; x++) begin
        logic b;
        b = (x == 0) ? btn_a : btn_b;
        m_walk[x] <= m_act[x] && (m_el[x] < W);
        m_dw[x]   <= !m_act[x] || ((m_el[x] >= W) && (((m_el[x] - W) / H) % 2 == 0));
        if (m_act[x]) begin
          if (lights == green(x)) m_el[x] <= m_el[x] + 1;
          else                    m_act[x] <= 1'b0;
          m_req[x] <= m_req[x] | b;
        end else if ((lights == green(x)) && (m_prev != green(x)) && !m_fault && (m_req[x] || b)) begin
          m_act[x] <= 1'b1;
          m_el[x]  <= 0;
          m_req[x] <= 1'b0;
        end else begin
          m_req[x] <= m_req[x] | b;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("outputs_vs_model", {25'd0, walk_a, dw_a, walk_b, dw_b, req_a, req_b, fault},
          {25'd0, m_walk[0], m_dw[0], m_walk[1], m_dw[1], m_req[0], m_req[1], m_fault});
      chk("walk_exclusive", {31'd0, walk_a & walk_b}, 32'd0);
    end
  end

  task automatic drive(input logic [5:0] l, input logic ba, input logic bb, input int n);
    lights = l;
    btn_a  = ba;
    btn_b  = bb;
    repeat (n) begin
      @(negedge clk);
      cnt_wa += int'(walk_a);
      cnt_wb += int'(walk_b);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    #1 clr_n = 1'b0;
    #3;
    chk("reset_outs", {25'd0, walk_a, dw_a, walk_b, dw_b, req_a, req_b, fault}, 32'b0101000);
    @(negedge clk);
    @(negedge clk);
    clr_n  = 1'b1;
    chk_en = 1'b1;

    // Idle all-red
    drive(6'b100100, 1'b0, 1'b0, 4);
    chk("idle_outs", {25'd0, walk_a, dw_a, walk_b, dw_b, req_a, req_b, fault}, 32'b0101000);

    // Request latched then granted; 8 WALK cycles then flashing 1,1,0,0,1,1
    drive(6'b100100, 1'b1, 1'b0, 1);
    chk("req_a_latched", {31'd0, req_a}, 32'd1);
    drive(GA, 1'b0, 1'b0, 1);
    chk("req_a_cleared_on_grant", {31'd0, req_a}, 32'd0);
    chk("walk_a_lags_state", {31'd0, walk_a}, 32'd0);
    drive(GA, 1'b0, 1'b0, 1);
    chk("walk_a_on", {30'd0, walk_a, dw_a}, 32'b10);
    drive(GA, 1'b0, 1'b0, 7);
    chk("walk_a_last", {30'd0, walk_a, dw_a}, 32'b10);
    drive(GA, 1'b0, 1'b0, 1);
    chk("flash_first", {30'd0, walk_a, dw_a}, 32'b01);
    drive(GA, 1'b0, 1'b0, 2);
    chk("flash_off", {30'd0, walk_a, dw_a}, 32'b00);
    drive(GA, 1'b0, 1'b0, 2);
    chk("flash_on_again", {30'd0, walk_a, dw_a}, 32'b01);
    drive(6'b100010, 1'b0, 1'b0, 2);
    chk("flash_end_steady_dw", {30'd0, walk_a, dw_a}, 32'b01);
    drive(6'b100100, 1'b0, 1'b0, 2);

    // Full light cycle without any request
    cnt_wa = 0;
    cnt_wb = 0;
    drive(GA, 1'b0, 1'b0, 4);
    drive(6'b100010, 1'b0, 1'b0, 2);
    drive(6'b100100, 1'b0, 1'b0, 2);
    drive(GB, 1'b0, 1'b0, 4);
    drive(6'b010100, 1'b0, 1'b0, 2);
    drive(6'b100100, 1'b0, 1'b0, 2);
    chk("no_request_no_walk", cnt_wa + cnt_wb, 32'd0);

    // Crossing B phase ends early after three green cycles
    drive(6'b100100, 1'b0, 1'b1, 1);
    chk("req_b_latched", {31'd0, req_b}, 32'd1);
    cnt_wb = 0;
    drive(GB, 1'b0, 1'b1, 1);
    chk("req_b_absorbed_by_grant", {31'd0, req_b}, 32'd0);
    drive(GB, 1'b0, 1'b1, 2);
    drive(6'b010100, 1'b0, 1'b0, 4);
    chk("walk_b_three_cycles", cnt_wb, 32'd3);
    chk("walk_b_back_to_dw", {30'd0, walk_b, dw_b}, 32'b01);
    drive(6'b100100, 1'b0, 1'b0, 2);

    // Illegal pattern during WALK A
    drive(6'b100100, 1'b1, 1'b0, 1);
    drive(GA, 1'b0, 1'b0, 3);
    chk("walk_a_before_fault", {31'd0, walk_a}, 32'd1);
    drive(6'b000001, 1'b0, 1'b0, 1);
    chk("fault_set", {31'd0, fault}, 32'd1);
    drive(6'b100100, 1'b0, 1'b0, 1);
    chk("fault_forces_dw", {30'd0, walk_a, dw_a}, 32'b01);
    cnt_wa = 0;
    drive(GA, 1'b1, 1'b0, 4);
    chk("no_grant_under_fault", cnt_wa, 32'd0);
    chk("req_latches_under_fault", {31'd0, req_a}, 32'd1);
    chk("fault_sticky", {31'd0, fault}, 32'd1);
    drive(6'b100100, 1'b0, 1'b0, 2);

    clr_n = 1'b0;
    drive(6'b100100, 1'b0, 1'b0, 2);
    clr_n = 1'b1;
    chk("fault_cleared_by_reset", {31'd0, fault}, 32'd0);
    drive(6'b100100, 1'b0, 1'b0, 1);

    // Asynchronous reset in the middle of flashing
    drive(6'b100100, 1'b1, 1'b0, 1);
    drive(GA, 1'b0, 1'b0, 1);
    drive(GA, 1'b1, 1'b0, 11);
    chk("mid_flash_state", {29'd0, walk_a, dw_a, req_a}, 32'b001);
    @(posedge clk);
    #2 clr_n = 1'b0;
    #1;
    chk("async_reset_outs", {25'd0, walk_a, dw_a, walk_b, dw_b, req_a, req_b, fault}, 32'b0101000);
    @(negedge clk);
    drive(6'b100100, 1'b0, 1'b0, 2);
    clr_n = 1'b1;
    drive(6'b100100, 1'b0, 1'b0, 3);
    chk("after_reset_idle", {25'd0, walk_a, dw_a, walk_b, dw_b, req_a, req_b, fault}, 32'b0101000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
